// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - Requester and output stream bundle for the packet-locked arbiter
interface stream_rr_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic [NUM_INPUTS*WIDTH-1:0] i_in_data;
  logic [NUM_INPUTS-1:0]       i_in_valid;
  logic [NUM_INPUTS-1:0]       i_in_last;
  logic [NUM_INPUTS-1:0]       o_in_ready;
  logic [WIDTH-1:0]            o_out_data;
  logic                        o_out_valid;
  logic                        o_out_last;
  logic [IDX_W-1:0]            o_out_source;
  logic                        i_out_ready;
  logic                        o_busy;

  modport slave (
    input  i_in_data, i_in_valid, i_in_last, i_out_ready,
    output o_in_ready, o_out_data, o_out_valid, o_out_last, o_out_source, o_busy
  );

  modport master (
    output i_in_data, i_in_valid, i_in_last, i_out_ready,
    input  o_in_ready, o_out_data, o_out_valid, o_out_last, o_out_source, o_busy
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - Packet-locked round-robin arbiter feeding one registered stream stage
module stream_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  stream_rr_arbiter_if.slave io_stream
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [IDX_W-1:0]      r_grant;
  logic [IDX_W-1:0]      w_pick;
  logic [IDX_W-1:0]      w_grant_inc;
  logic [WIDTH-1:0]      r_out_data;
  logic [WIDTH-1:0]      w_grant_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [IDX_W-1:0]      r_out_source;
  logic [NUM_INPUTS-1:0] w_in_ready;
  logic                  w_any_valid;
  logic                  w_out_free;
  logic                  w_grant_valid;
  logic                  w_grant_last;
  logic                  w_accept;
  int                    w_dist;
  int                    w_best;

  assign w_out_free    = !r_out_valid || io_stream.i_out_ready;
  assign w_grant_valid = io_stream.i_in_valid[r_grant];
  assign w_grant_last  = io_stream.i_in_last[r_grant];
  assign w_grant_data  = io_stream.i_in_data[r_grant*WIDTH +: WIDTH];
  assign w_accept      = (r_state == ST_LOCKED) && w_grant_valid && w_out_free;
  assign w_grant_inc   = (r_grant == IDX_W'(NUM_INPUTS - 1)) ? '0 : r_grant + IDX_W'(1);

  // Winner is the valid requester at the smallest cyclic distance from the pointer
  always_comb begin
    w_pick      = '0;
    w_any_valid = 1'b0;
    w_best      = NUM_INPUTS;
    w_dist      = 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_INPUTS;
      end
      if (io_stream.i_in_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_pick      = IDX_W'(i);
        w_any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if ((r_state == ST_LOCKED) && (r_grant == IDX_W'(i))) begin
        w_in_ready[i] = w_out_free;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stalled granted requester keeps the lock; only its last beat releases it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_accept && w_grant_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_source <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any_valid) begin
        r_grant <= w_pick;
      end
      if (w_accept && w_grant_last) begin
        r_rr_ptr <= w_grant_inc;
      end
      if (w_accept) begin
        r_out_data   <= w_grant_data;
        r_out_last   <= w_grant_last;
        r_out_source <= r_grant;
        r_out_valid  <= 1'b1;
      end else if (io_stream.i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_stream.o_in_ready   = w_in_ready;
  assign io_stream.o_out_data   = r_out_data;
  assign io_stream.o_out_valid  = r_out_valid;
  assign io_stream.o_out_last   = r_out_last;
  assign io_stream.o_out_source = r_out_source;
  assign io_stream.o_busy       = (r_state == ST_LOCKED);
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - Self-checking bench for stream_rr_arbiter
module tb_stream_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [3:0]  drv_valid = '0;
  logic [3:0]  drv_last  = '0;
  logic [31:0] drv_data  = '0;

  stream_rr_arbiter_if #(.WIDTH(WIDTH), .NUM_INPUTS(N)) bus ();

  stream_rr_arbiter #(.WIDTH(WIDTH), .NUM_INPUTS(N)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_stream (bus)
  );

  always #5 clk = ~clk;

  task automatic apply();
    bus.i_in_valid = drv_valid;
    bus.i_in_last  = drv_last;
    bus.i_in_data  = drv_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv_valid = '0; drv_last = '0; drv_data = '0;
    apply();
    bus.i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv_valid = 4'hF; drv_last = 4'hF; drv_data = 32'hDEADBEEF;
    apply();
    bus.i_out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0000) $display("FAIL reset_ready: got %b exp 0000", bus.o_in_ready); else n_pass++;
    n_checks++; if (bus.o_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", bus.o_out_valid); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", bus.o_busy); else n_pass++;
    n_checks++; if (bus.o_out_data !== 8'h00) $display("FAIL reset_out_data: got %h exp 00", bus.o_out_data); else n_pass++;
    n_checks++; if (bus.o_out_last !== 1'b0) $display("FAIL reset_out_last: got %b exp 0", bus.o_out_last); else n_pass++;
    n_checks++; if (bus.o_out_source !== 2'd0) $display("FAIL reset_out_source: got %0d exp 0", bus.o_out_source); else n_pass++;
  endtask

  task automatic test_single_packet();
    do_reset();
    drv_valid = 4'b0100; drv_last = 4'b0000; drv_data[23:16] = 8'hA1;
    apply();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0000) $display("FAIL single_idle_ready: got %b exp 0000", bus.o_in_ready); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL single_idle_busy: got %b exp 0", bus.o_busy); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0100) $display("FAIL single_ready_c1: got %b exp 0100", bus.o_in_ready); else n_pass++;
    n_checks++; if (bus.o_out_valid !== 1'b0) $display("FAIL single_no_out_c1: got %b exp 0", bus.o_out_valid); else n_pass++;
    tick();
    drv_data[23:16] = 8'hA2; apply();
    @(negedge clk);
    n_checks++; if ({bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data} !== {1'b1, 1'b0, 2'd2, 8'hA1})
      $display("FAIL single_beat0: got v%b l%b s%0d d%h exp v1 l0 s2 dA1", bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data); else n_pass++;
    n_checks++; if (bus.o_in_ready !== 4'b0100) $display("FAIL single_ready_c2: got %b exp 0100", bus.o_in_ready); else n_pass++;
    tick();
    drv_data[23:16] = 8'hA3; drv_last = 4'b0100; apply();
    @(negedge clk);
    n_checks++; if ({bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data} !== {1'b1, 1'b0, 2'd2, 8'hA2})
      $display("FAIL single_beat1: got v%b l%b s%0d d%h exp v1 l0 s2 dA2", bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data); else n_pass++;
    tick();
    drv_valid = '0; drv_last = '0; apply();
    @(negedge clk);
    n_checks++; if ({bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data} !== {1'b1, 1'b1, 2'd2, 8'hA3})
      $display("FAIL single_beat2: got v%b l%b s%0d d%h exp v1 l1 s2 dA3", bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data); else n_pass++;
    n_checks++; if (bus.o_busy !== 1'b0) $display("FAIL single_busy_after: got %b exp 0", bus.o_busy); else n_pass++;
    tick();
    // Pointer should now sit at 3, so 3 beats 1 when both are valid
    drv_valid = 4'b1010; drv_last = 4'b1010; apply();
    @(negedge clk);
    n_checks++; if (bus.o_out_valid !== 1'b0) $display("FAIL single_out_drained: got %b exp 0", bus.o_out_valid); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b1000) $display("FAIL single_ptr_is_3: got %b exp 1000", bus.o_in_ready); else n_pass++;
  endtask

  task automatic test_round_robin();
    int cnt[4];
    logic [3:0] acc;
    logic [11:0] slots[$];
    logic [11:0] e;
    int k;
    int pkt;
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int cyc = 0; cyc < 60 && slots.size() < 14; cyc++) begin
      for (int i = 0; i < N; i++) begin
        drv_valid[i] = 1'b1;
        drv_last[i]  = (cnt[i] % 2) == 1;
        drv_data[i*8 +: 8] = 8'(i*16 + cnt[i]);
      end
      apply();
      @(negedge clk);
      acc = bus.o_in_ready & drv_valid;
      if (bus.o_out_valid || slots.size() > 0)
        slots.push_back({bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data});
      tick();
      for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
    end
    n_checks++; if (slots.size() != 14) $display("FAIL rr_slot_count: got %0d exp 14", slots.size()); else n_pass++;
    if (slots.size() == 14) begin
      for (int p = 0; p < 5; p++) begin
        k = p % 4; pkt = p / 4;
        e = {1'b1, 1'b0, 2'(k), 8'(k*16 + 2*pkt)};
        n_checks++; if (slots[3*p] !== e) $display("FAIL rr_pkt%0d_beat0: got %h exp %h", p, slots[3*p], e); else n_pass++;
        e = {1'b1, 1'b1, 2'(k), 8'(k*16 + 2*pkt + 1)};
        n_checks++; if (slots[3*p+1] !== e) $display("FAIL rr_pkt%0d_beat1: got %h exp %h", p, slots[3*p+1], e); else n_pass++;
        if (p < 4) begin
          n_checks++; if (slots[3*p+2][11] !== 1'b0) $display("FAIL rr_gap%0d: got valid %b exp 0", p, slots[3*p+2][11]); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b;
    int stall;
    logic done;
    logic start;
    logic acc;
    logic [10:0] snap;
    logic [8:0] got[$];
    do_reset();
    b = 0; stall = 0; done = 1'b0; start = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      drv_valid[0] = b < 4; drv_last[0] = b == 3; drv_data[7:0] = 8'(8'h30 + b);
      apply();
      @(negedge clk);
      acc = bus.o_in_ready[0] & drv_valid[0];
      if (stall > 0) begin
        if (stall == 5) snap = {bus.o_out_last, bus.o_out_source, bus.o_out_data};
        else begin
          n_checks++; if ({bus.o_out_last, bus.o_out_source, bus.o_out_data} !== snap)
            $display("FAIL bp_frozen: got %h exp %h", {bus.o_out_last, bus.o_out_source, bus.o_out_data}, snap); else n_pass++;
        end
        n_checks++; if (bus.o_in_ready !== 4'b0000) $display("FAIL bp_ready: got %b exp 0000", bus.o_in_ready); else n_pass++;
        n_checks++; if (bus.o_out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b exp 1", bus.o_out_valid); else n_pass++;
      end
      if (bus.o_out_valid && bus.i_out_ready) got.push_back({bus.o_out_last, bus.o_out_data});
      if (!done && bus.o_out_valid && bus.o_out_data == 8'h31) start = 1'b1;
      tick();
      if (acc) b++;
      if (start) begin
        bus.i_out_ready = 1'b0; stall = 5; start = 1'b0; done = 1'b1;
      end else if (stall > 0) begin
        stall--;
        if (stall == 0) bus.i_out_ready = 1'b1;
      end
    end
    n_checks++; if (got.size() != 4) $display("FAIL bp_beat_count: got %0d exp 4", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++; if (got[i] !== {i == 3, 8'(8'h30 + i)}) $display("FAIL bp_beat%0d: got %h exp %h", i, got[i], {i == 3, 8'(8'h30 + i)}); else n_pass++;
    end
  endtask

  task automatic test_valid_drop();
    int b1;
    int drop;
    logic dropped;
    logic sent3;
    logic [3:0] acc;
    logic [9:0] got[$];
    logic [9:0] exp_q[4];
    do_reset();
    b1 = 0; drop = 0; dropped = 1'b0; sent3 = 1'b0;
    exp_q[0] = {2'd1, 8'h50}; exp_q[1] = {2'd1, 8'h51}; exp_q[2] = {2'd1, 8'h52}; exp_q[3] = {2'd3, 8'h70};
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      drv_valid[1] = (b1 < 3) && (drop == 0); drv_last[1] = b1 == 2; drv_data[15:8] = 8'(8'h50 + b1);
      drv_valid[3] = !sent3; drv_last[3] = 1'b1; drv_data[31:24] = 8'h70;
      apply();
      @(negedge clk);
      acc = bus.o_in_ready & drv_valid;
      if (drop > 0) begin
        n_checks++; if (bus.o_busy !== 1'b1) $display("FAIL drop_busy: got %b exp 1", bus.o_busy); else n_pass++;
        n_checks++; if (bus.o_in_ready !== 4'b0010) $display("FAIL drop_ready: got %b exp 0010", bus.o_in_ready); else n_pass++;
      end
      if (bus.o_out_valid && bus.i_out_ready) got.push_back({bus.o_out_source, bus.o_out_data});
      tick();
      if (acc[1]) b1++;
      if (acc[3]) sent3 = 1'b1;
      if (drop > 0) drop--;
      else if (!dropped && b1 == 1) begin drop = 3; dropped = 1'b1; end
    end
    n_checks++; if (got.size() != 4) $display("FAIL drop_beat_count: got %0d exp 4", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL drop_beat%0d: got %h exp %h", i, got[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    drv_valid = 4'b1000; drv_last = 4'b1000; drv_data[31:24] = 8'hC3;
    apply();
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b1000) $display("FAIL wrap_first_grant: got %b exp 1000", bus.o_in_ready); else n_pass++;
    tick();
    drv_valid = 4'b1001; drv_last = 4'b1001; drv_data[7:0] = 8'h0C;
    apply();
    @(negedge clk);
    n_checks++; if ({bus.o_busy, bus.o_in_ready} !== 5'b0_0000) $display("FAIL wrap_bubble: got busy %b ready %b exp 0 0000", bus.o_busy, bus.o_in_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0001) $display("FAIL wrap_grant0: got %b exp 0001", bus.o_in_ready); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drv_valid = 4'b0100; drv_last = '0; drv_data[23:16] = 8'hA1;
    apply();
    tick();
    tick();
    drv_data[23:16] = 8'hA2; apply();
    #2;
    n_checks++; if (bus.o_out_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b exp 1", bus.o_out_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data} !== 12'h000)
      $display("FAIL areset_out: got v%b l%b s%0d d%h exp all 0", bus.o_out_valid, bus.o_out_last, bus.o_out_source, bus.o_out_data); else n_pass++;
    n_checks++; if ({bus.o_busy, bus.o_in_ready} !== 5'b0_0000) $display("FAIL areset_ctrl: got busy %b ready %b exp 0 0000", bus.o_busy, bus.o_in_ready); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv_valid = 4'b0110; drv_last = 4'b0110; apply();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0000) $display("FAIL areset_idle: got %b exp 0000", bus.o_in_ready); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.o_in_ready !== 4'b0010) $display("FAIL areset_grant1: got %b exp 0010", bus.o_in_ready); else n_pass++;
  endtask

  task automatic test_random();
    int owner;
    int ptr;
    int pkts;
    int k;
    int rem[4];
    logic found;
    logic ov;
    logic ol;
    logic [7:0] od;
    logic [1:0] os;
    logic [3:0] er;
    logic [3:0] acc;
    do_reset();
    owner = -1; ptr = 0; pkts = 0; ov = 1'b0; ol = 1'b0; od = '0; os = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      er = (owner >= 0 && (!ov || bus.i_out_ready)) ? 4'(1 << owner) : 4'b0000;
      n_checks++; if (bus.o_in_ready !== er) $display("FAIL rand_ready c%0d: got %b exp %b", cyc, bus.o_in_ready, er); else n_pass++;
      n_checks++; if (bus.o_busy !== (owner >= 0)) $display("FAIL rand_busy c%0d: got %b exp %b", cyc, bus.o_busy, owner >= 0); else n_pass++;
      n_checks++; if (bus.o_out_valid !== ov) $display("FAIL rand_out_valid c%0d: got %b exp %b", cyc, bus.o_out_valid, ov); else n_pass++;
      if (ov) begin
        n_checks++; if ({bus.o_out_last, bus.o_out_source, bus.o_out_data} !== {ol, os, od})
          $display("FAIL rand_beat c%0d: got l%b s%0d d%h exp l%b s%0d d%h", cyc, bus.o_out_last, bus.o_out_source, bus.o_out_data, ol, os, od); else n_pass++;
      end
      acc = drv_valid & er;
      if (owner >= 0 && acc != 0) begin
        ov = 1'b1; od = drv_data[owner*8 +: 8]; ol = drv_last[owner]; os = 2'(owner);
        if (ol) begin ptr = (owner + 1) % N; owner = -1; pkts++; end
      end else begin
        if (bus.i_out_ready) ov = 1'b0;
        if (owner < 0) begin
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (!found && drv_valid[k]) begin owner = k; found = 1'b1; end
          end
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin rem[i]--; drv_data[i*8 +: 8] = 8'($urandom); end
        if (rem[i] == 0 && ($urandom % 3) == 0) rem[i] = $urandom_range(1, 4);
        drv_valid[i] = (rem[i] > 0) && (($urandom % 4) != 0);
        drv_last[i]  = rem[i] == 1;
      end
      bus.i_out_ready = ($urandom % 4) != 0;
      apply();
    end
    n_checks++; if (pkts < 20) $display("FAIL rand_progress: got %0d packets exp >= 20", pkts); else n_pass++;
  endtask

  initial begin
    bus.i_in_valid  = '0;
    bus.i_in_last   = '0;
    bus.i_in_data   = '0;
    bus.i_out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_valid_drop();
    test_pointer_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
